// File: rtl/ram_rw_ctl.sv
// ram_rw_ctl: host byte-command initiator for the RAM debug read/write port.
// Optional trailing checksum byte per transfer: define RAM_RW_CTL_CHKSUM_EN.
module ram_rw_ctl #(
   parameter int XLEN       = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [7:0]      rx_data_i,
   input  logic            rx_valid_i,
   output logic            rx_ready_o,
   output logic [7:0]      tx_data_o,
   output logic            tx_valid_o,
   input  logic            tx_ready_i,
   output logic            ram_rw_sel_o,
   output logic [XLEN-1:0] ram_rw_addr_o,
   output logic [XLEN-1:0] ram_wr_data_o,
   output logic [3:0]      ram_wr_byte_en_o,
   input  logic [7:0]      ram_rd_data_i,
   output logic            busy_o,
   output logic            err_o
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LEN,
      WR_ACCEPT,
      WR_STROBE,
      RD_WAIT,
      RD_SEND
`ifdef RAM_RW_CTL_CHKSUM_EN
      , SUM_SEND
`endif
   } state_t;

   state_t          state, nxt_state;
   logic [XLEN-1:0] addr, nxt_addr;
   logic [15:0]     len, nxt_len;
   logic [1:0]      cnt, nxt_cnt;
   logic            is_rd, nxt_is_rd;
   logic [7:0]      tx_data, nxt_tx_data;
   logic            tx_valid, nxt_tx_valid;
   logic [XLEN-1:0] wr_data, nxt_wr_data;
   logic [3:0]      byte_en, nxt_byte_en;
   logic            rx_ready, nxt_rx_ready;
   logic            sel, nxt_sel;
   logic            busy, nxt_busy;
   logic            err, nxt_err;
   logic            rx_hs, tx_hs;
   logic [15:0]     full_len;
`ifdef RAM_RW_CTL_CHKSUM_EN
   logic [7:0]      sum, nxt_sum;
`endif

   assign rx_ready_o       = rx_ready;
   assign tx_data_o        = tx_data;
   assign tx_valid_o       = tx_valid;
   assign ram_rw_sel_o     = sel;
   assign ram_rw_addr_o    = addr;
   assign ram_wr_data_o    = wr_data;
   assign ram_wr_byte_en_o = byte_en;
   assign busy_o           = busy;
   assign err_o            = err;

   assign rx_hs    = rx_valid_i & rx_ready;
   assign tx_hs    = tx_valid & tx_ready_i;
   // Length arrives LSB first; this is the value once the 2nd byte lands.
   assign full_len = {rx_data_i, len[15:8]};

   // Next-state, datapath and registered-output decode.
   always_comb begin
      nxt_state    = state;
      nxt_addr     = addr;
      nxt_len      = len;
      nxt_cnt      = cnt;
      nxt_is_rd    = is_rd;
      nxt_tx_data  = tx_data;
      nxt_tx_valid = tx_valid;
      nxt_wr_data  = wr_data;
      nxt_err      = 1'b0;
`ifdef RAM_RW_CTL_CHKSUM_EN
      nxt_sum      = sum;
`endif
      case (state)
         IDLE: begin
            if (rx_hs) begin
               nxt_cnt = 2'd0;
               case (rx_data_i)
                  8'h2A: nxt_state = ADDR;
                  8'h2B, 8'h2C: begin
                     nxt_state = LEN;
                     nxt_is_rd = (rx_data_i == 8'h2C);
`ifdef RAM_RW_CTL_CHKSUM_EN
                     nxt_sum   = 8'h00;
`endif
                  end
                  default: nxt_err = 1'b1;
               endcase
            end
         end
         ADDR: begin
            if (rx_hs) begin
               // Shift in LSB first; after 4 bytes byte 0 sits at [7:0].
               nxt_addr = {rx_data_i, addr[XLEN-1:8]};
               nxt_cnt  = cnt + 2'd1;
               if (cnt == 2'd3) nxt_state = IDLE;
            end
         end
         LEN: begin
            if (rx_hs) begin
               nxt_len = full_len;
               nxt_cnt = 2'd0;
               if (cnt == 2'd1) begin
                  if (full_len == 16'd0) nxt_state = IDLE;
                  else if (is_rd)        nxt_state = RD_WAIT;
                  else                   nxt_state = WR_ACCEPT;
               end else begin
                  nxt_cnt = 2'd1;
               end
            end
         end
         WR_ACCEPT: begin
            if (rx_hs) begin
               nxt_wr_data = {(XLEN/8){rx_data_i}};
               nxt_state   = WR_STROBE;
`ifdef RAM_RW_CTL_CHKSUM_EN
               nxt_sum     = sum + rx_data_i;
`endif
            end
         end
         WR_STROBE: begin
            nxt_addr = addr + XLEN'(1);
            nxt_len  = len - 16'd1;
            if (len == 16'd1) begin
`ifdef RAM_RW_CTL_CHKSUM_EN
               nxt_state    = SUM_SEND;
               nxt_tx_data  = sum;
               nxt_tx_valid = 1'b1;
`else
               nxt_state    = IDLE;
`endif
            end else begin
               nxt_state = WR_ACCEPT;
            end
         end
         RD_WAIT: begin
            if (cnt == 2'(RD_LATENCY)) begin
               nxt_tx_data  = ram_rd_data_i;
               nxt_tx_valid = 1'b1;
               nxt_state    = RD_SEND;
`ifdef RAM_RW_CTL_CHKSUM_EN
               nxt_sum      = sum + ram_rd_data_i;
`endif
            end else begin
               nxt_cnt = cnt + 2'd1;
            end
         end
         RD_SEND: begin
            if (tx_hs) begin
               nxt_tx_valid = 1'b0;
               nxt_addr     = addr + XLEN'(1);
               nxt_len      = len - 16'd1;
               nxt_cnt      = 2'd0;
               if (len == 16'd1) begin
`ifdef RAM_RW_CTL_CHKSUM_EN
                  nxt_state    = SUM_SEND;
                  nxt_tx_data  = sum;
                  nxt_tx_valid = 1'b1;
`else
                  nxt_state    = IDLE;
`endif
               end else begin
                  nxt_state = RD_WAIT;
               end
            end
         end
`ifdef RAM_RW_CTL_CHKSUM_EN
         SUM_SEND: begin
            if (tx_hs) begin
               nxt_tx_valid = 1'b0;
               nxt_state    = IDLE;
            end
         end
`endif
         default: nxt_state = IDLE;
      endcase

      nxt_busy     = (nxt_state != IDLE);
      nxt_rx_ready = (nxt_state == IDLE) || (nxt_state == ADDR) ||
                     (nxt_state == LEN)  || (nxt_state == WR_ACCEPT);
      nxt_sel      = nxt_busy && (nxt_state != ADDR) &&
                     (nxt_state != LEN);
      nxt_byte_en  = (nxt_state == WR_STROBE) ?
                     (4'b0001 << nxt_addr[1:0]) : 4'b0000;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         addr     <= '0;
         len      <= '0;
         cnt      <= '0;
         is_rd    <= 1'b0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         wr_data  <= '0;
         byte_en  <= '0;
         rx_ready <= 1'b0;
         sel      <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
`ifdef RAM_RW_CTL_CHKSUM_EN
         sum      <= '0;
`endif
      end else begin
         state    <= nxt_state;
         addr     <= nxt_addr;
         len      <= nxt_len;
         cnt      <= nxt_cnt;
         is_rd    <= nxt_is_rd;
         tx_data  <= nxt_tx_data;
         tx_valid <= nxt_tx_valid;
         wr_data  <= nxt_wr_data;
         byte_en  <= nxt_byte_en;
         rx_ready <= nxt_rx_ready;
         sel      <= nxt_sel;
         busy     <= nxt_busy;
         err      <= nxt_err;
`ifdef RAM_RW_CTL_CHKSUM_EN
         sum      <= nxt_sum;
`endif
      end
   end

endmodule

// File: tb/tb_ram_rw_ctl.sv
// tb_ram_rw_ctl: scoreboard bench for ram_rw_ctl with a 1-cycle RAM model.
// Define RAM_RW_CTL_CHKSUM_EN here too to exercise the trailing sum byte.
module tb_ram_rw_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready = 1'b1;
   logic        ram_rw_sel_o;
   logic [31:0] ram_rw_addr_o;
   logic [31:0] ram_wr_data_o;
   logic [3:0]  ram_wr_byte_en_o;
   logic [7:0]  ram_rd = 8'h00;
   logic        busy_o;
   logic        err_o;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  en;
      logic [31:0] d;
   } wexp_t;

   wexp_t       wr_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  cmd[$];
   logic [7:0]  mem[logic [31:0]];
   int          applied = 0;
   int          miscomp = 0;

   ram_rw_ctl #(.XLEN(32), .RD_LATENCY(1)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .rx_data_i        (rx_data),
      .rx_valid_i       (rx_valid),
      .rx_ready_o       (rx_ready_o),
      .tx_data_o        (tx_data_o),
      .tx_valid_o       (tx_valid_o),
      .tx_ready_i       (tx_ready),
      .ram_rw_sel_o     (ram_rw_sel_o),
      .ram_rw_addr_o    (ram_rw_addr_o),
      .ram_wr_data_o    (ram_wr_data_o),
      .ram_wr_byte_en_o (ram_wr_byte_en_o),
      .ram_rd_data_i    (ram_rd),
      .busy_o           (busy_o),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   // RAM model: byte store, registered read (latency 1).
   always @(posedge clk) begin
      if (ram_wr_byte_en_o != 4'b0000)
         mem[ram_rw_addr_o] = ram_wr_data_o[7:0];
      ram_rd <= mem.exists(ram_rw_addr_o) ?
                mem[ram_rw_addr_o] : 8'h00;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscomp++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [3:0] en,
                         input logic [7:0] b);
      wexp_t e;
      e.a  = a;
      e.en = en;
      e.d  = {4{b}};
      wr_q.push_back(e);
   endtask

   // Send one byte over rx valid/ready; returns 1ns after the handshake.
   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready_o) begin
         applied++;
         miscomp++;
         $display("FAIL rx_timeout byte=%h got=0 want=1", b);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_cmd();
      foreach (cmd[i]) send(cmd[i]);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      @(negedge clk);
      while (busy_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(busy_o), 32'd0);
   endtask

   // Scoreboard monitor: pops on every strobe and tx handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (ram_wr_byte_en_o != 4'b0000) begin
            applied++;
            if (wr_q.size() == 0) begin
               miscomp++;
               $display("FAIL wr_unexpected got=%h/%b want=none",
                        ram_rw_addr_o, ram_wr_byte_en_o);
            end else begin
               wexp_t e;
               e = wr_q.pop_front();
               if (ram_rw_addr_o !== e.a || ram_wr_byte_en_o !== e.en ||
                   ram_wr_data_o !== e.d || ram_rw_sel_o !== 1'b1) begin
                  miscomp++;
                  $display("FAIL wr_strobe got=%h/%b/%h/%b want=%h/%b/%h/1",
                           ram_rw_addr_o, ram_wr_byte_en_o, ram_wr_data_o,
                           ram_rw_sel_o, e.a, e.en, e.d);
               end
            end
         end
         if (tx_valid_o && tx_ready) begin
            applied++;
            if (tx_q.size() == 0) begin
               miscomp++;
               $display("FAIL tx_unexpected got=%h want=none", tx_data_o);
            end else begin
               logic [7:0] t;
               t = tx_q.pop_front();
               if (tx_data_o !== t) begin
                  miscomp++;
                  $display("FAIL tx_byte got=%h want=%h", tx_data_o, t);
               end
            end
         end
      end
   end

   initial begin
      int  n;
      logic seen;

      mem[32'h0002_0010] = 8'h3C;
      mem[32'h0002_0011] = 8'hC3;

      // Reset values.
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_ready", 32'(rx_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_sel", 32'(ram_rw_sel_o), 32'd0);
      chk("rst_addr", ram_rw_addr_o, 32'd0);
      chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_ready", 32'(rx_ready_o), 32'd1);

      // Write AA BB CC at 0.
      exp_wr(32'h0, 4'b0001, 8'hAA);
      exp_wr(32'h1, 4'b0010, 8'hBB);
      exp_wr(32'h2, 4'b0100, 8'hCC);
`ifdef RAM_RW_CTL_CHKSUM_EN
      tx_q.push_back(8'h31);
`endif
      cmd = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h00};
      send_cmd();
      chk("addr_sel_low", 32'(ram_rw_sel_o), 32'd0);
      send(8'h2B);
      send(8'h03);
      chk("len_sel_low", 32'(ram_rw_sel_o), 32'd0);
      chk("len_busy", 32'(busy_o), 32'd1);
      send(8'h00);
      chk("data_sel_high", 32'(ram_rw_sel_o), 32'd1);
      cmd = '{8'hAA, 8'hBB, 8'hCC};
      send_cmd();
      wait_idle("wr_idle");
      chk("wr_sel_released", 32'(ram_rw_sel_o), 32'd0);

      // Read two bytes with tx backpressure.
      tx_ready = 1'b0;
      tx_q.push_back(8'h3C);
      tx_q.push_back(8'hC3);
`ifdef RAM_RW_CTL_CHKSUM_EN
      tx_q.push_back(8'hFF);
`endif
      cmd = '{8'h2A, 8'h10, 8'h00, 8'h02, 8'h00, 8'h2C, 8'h02, 8'h00};
      send_cmd();
      n = 0;
      while (!tx_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rd_valid", 32'(tx_valid_o), 32'd1);
      chk("rd_no_rx_ready", 32'(rx_ready_o), 32'd0);
      repeat (5) begin
         @(negedge clk);
         chk("rd_hold_data", 32'(tx_data_o), 32'h3C);
      end
      @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_idle("rd_idle");
      chk("rd_final_addr", ram_rw_addr_o, 32'h0002_0012);

      // Address wrap on write.
      exp_wr(32'hFFFF_FFFF, 4'b1000, 8'h11);
      exp_wr(32'h0000_0000, 4'b0001, 8'h22);
`ifdef RAM_RW_CTL_CHKSUM_EN
      tx_q.push_back(8'h33);
`endif
      cmd = '{8'h2A, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h2B, 8'h02, 8'h00, 8'h11, 8'h22};
      send_cmd();
      wait_idle("wrap_idle");
      chk("wrap_addr", ram_rw_addr_o, 32'h0000_0001);

      // Zero-length read: no RAM select, no tx.
      cmd = '{8'h2C, 8'h00, 8'h00};
      send_cmd();
      chk("zero_busy", 32'(busy_o), 32'd0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ram_rw_sel_o || tx_valid_o) seen = 1'b1;
      end
      chk("zero_quiet", 32'(seen), 32'd0);

      // Unknown opcode.
      send(8'h55);
      chk("err_pulse", 32'(err_o), 32'd1);
      chk("err_busy", 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
      chk("err_clear", 32'(err_o), 32'd0);
      cmd = '{8'h2A, 8'h01, 8'h02, 8'h03, 8'h04};
      send_cmd();
      chk("after_err_addr", ram_rw_addr_o, 32'h0403_0201);

`ifdef RAM_RW_CTL_CHKSUM_EN
      exp_wr(32'h100, 4'b0001, 8'h01);
      exp_wr(32'h101, 4'b0010, 8'h02);
      exp_wr(32'h102, 4'b0100, 8'h03);
      tx_q.push_back(8'h06);
      cmd = '{8'h2A, 8'h00, 8'h01, 8'h00, 8'h00,
              8'h2B, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03};
      send_cmd();
      wait_idle("sum_wr_idle");
      tx_q.push_back(8'h01);
      tx_q.push_back(8'h02);
      tx_q.push_back(8'h03);
      tx_q.push_back(8'h06);
      cmd = '{8'h2A, 8'h00, 8'h01, 8'h00, 8'h00, 8'h2C, 8'h03, 8'h00};
      send_cmd();
      wait_idle("sum_rd_idle");
      cmd = '{8'h2A, 8'h01, 8'h02, 8'h03, 8'h04};
      send_cmd();
`endif

      // Reset during a write strobe.
      exp_wr(32'h0403_0201, 4'b0010, 8'h77);
      cmd = '{8'h2B, 8'h01, 8'h00, 8'h77};
      send_cmd();
      chk("strobe_live", 32'(ram_wr_byte_en_o), 32'h2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_en", 32'(ram_wr_byte_en_o), 32'd0);
      chk("arst_sel", 32'(ram_rw_sel_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_addr", ram_rw_addr_o, 32'd0);
      chk("arst_wdata", ram_wr_data_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_busy", 32'(busy_o), 32'd0);
      chk("rel_ready", 32'(rx_ready_o), 32'd1);

      repeat (4) @(negedge clk);
      chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk("tx_q_drained", 32'(tx_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               applied, miscomp);
      $finish;
   end

endmodule
